adsr_phase: RTL and testbench
=============================

ADSR_PHASE -- requirements
Module: adsr_phase

Interface
REQ-001 SHALL have parameter TOTAL_BITS, default 32, total width of every fixed-point value.
REQ-002 SHALL have parameter FRACTIONAL_BITS, default 16, number of fraction bits; all values are signed Q(TOTAL_BITS-FRACTIONAL_BITS).FRACTIONAL_BITS.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port gate  input  1  note held; a rising edge starts attack, a falling edge starts release.
REQ-006 SHALL have port tick  input  1  sample strobe; one phase step per cycle in which tick is high.
REQ-007 SHALL have port retrig  input  1  restart-attack request (see Configuration).
REQ-008 SHALL have ports attack_step, decay_step, release_step  input  TOTAL_BITS  non-negative per-tick increments, Q format.
REQ-009 SHALL have port sustain_level  input  TOTAL_BITS  sustain target, valid range [-1.0, 0].
REQ-010 SHALL have port x_out  output  TOTAL_BITS  registered exponent argument in [-1.0, 0], fed directly to the e^x stage.
REQ-011 SHALL have port x_valid  output  1  one-cycle pulse marking an updated x_out.
REQ-012 SHALL have port state_out  output  3  current state encoding.
REQ-013 SHALL have port active  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement states IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
REQ-015 SHALL register gate internally and detect edges by comparing gate against its previous value.
REQ-016 SHALL move from IDLE or RELEASE to ATTACK on a gate rising edge, keeping the current x_out (no jump).
REQ-017 SHALL move from ATTACK, DECAY or SUSTAIN to RELEASE on a gate falling edge.
REQ-018 SHALL, when an edge and tick coincide, apply the transition first and then the step of the new state in the same cycle.
REQ-019 SHALL, on tick in ATTACK, set x = min(x + attack_step, 0); on reaching 0, go to DECAY.
REQ-020 SHALL, on tick in DECAY, set x = max(x - decay_step, sustain_level); on reaching sustain_level, go to SUSTAIN.
REQ-021 SHALL hold x in SUSTAIN; a change of sustain_level while in SUSTAIN SHALL be adopted on the next tick.
REQ-022 SHALL, on tick in RELEASE, set x = max(x - release_step, MIN_X); on reaching MIN_X, go to IDLE.
REQ-023 SHALL hold x and state when the active state's step is 0 (stall, no transition).
REQ-024 SHALL evaluate add/subtract at TOTAL_BITS+1 bits so that no step value wraps before clamping.
REQ-025 SHALL update x_out and pulse x_valid exactly one cycle after each tick; x_valid SHALL stay low without tick, including in IDLE.
REQ-026 SHALL define MIN_X as -1.0, i.e. -(2**FRACTIONAL_BITS).

Reset
REQ-027 SHALL, on reset, force state IDLE, x_out=MIN_X, x_valid=0, active=0 and internal previous-gate=0, overriding any tick or edge in that cycle.
REQ-028 SHALL treat gate held high through reset release as a rising edge on the first non-reset cycle.

Configuration
REQ-029 SHALL, with ADSR_RETRIGGER_EN defined, restart ATTACK from x=MIN_X when retrig is high, gate is high and the state is ATTACK, DECAY or SUSTAIN.
REQ-030 SHALL, without ADSR_RETRIGGER_EN, ignore retrig entirely.

Structure
REQ-031 SHALL place the state enum, value_type typedef and MIN_X constant in shared package adsr_pkg.
REQ-032 SHALL use one combinational sub-module step_clamp (add or subtract step, clamp to limit, flag limit reached).

Verification
REQ-033 SHALL check: reset, gate=1, attack_step=0x4000, tick every cycle -> x_out -0xC000, -0x8000, -0x4000, 0x0, then state DECAY.
REQ-034 SHALL check: DECAY with decay_step=0x3000, sustain_level=-0x8000 -> x_out -0x3000, -0x6000, -0x8000, then state SUSTAIN, x held.
REQ-035 SHALL check: gate falls in SUSTAIN at x=-0x8000, release_step=0x5000 -> -0xD000, -0x10000, then state IDLE, active=0.
REQ-036 SHALL check: gate rises in RELEASE at x=-0xD000 with tick in same cycle, attack_step=0x1000 -> ATTACK, x_out=-0xC000 next cycle.
REQ-037 SHALL check: attack_step=0x7FFFFFFF from x=-0x10000 -> x_out=0 without wrap; reset asserted mid-DECAY -> IDLE, x_out=-0x10000.
REQ-038 SHALL check: with ADSR_RETRIGGER_EN, retrig in SUSTAIN -> ATTACK, x_out=-0x10000; without it, no change.

Source files
------------

// File: rtl/adsr_pkg.sv
// Shared types and constants for the ADSR phase generator.
package adsr_pkg;

    localparam int VALUE_BITS = 32;
    localparam int FRAC_BITS  = 16;

    typedef logic signed [VALUE_BITS-1:0] value_type;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } adsr_state_e;

    // -1.0 in a Q format with `frac` fraction bits; callers narrow to their width.
    function automatic longint min_x_of(input int frac);
        return -(64'sd1 <<< frac);
    endfunction

    localparam value_type MIN_X = value_type'(min_x_of(FRAC_BITS));

endpackage

// File: rtl/step_clamp.sv
// Adds or subtracts a step one bit wider than the operands, then clamps to a limit.
module step_clamp #(
    parameter int W = 32
) (
    input  logic signed [W-1:0] x_i,
    input  logic signed [W-1:0] step_i,
    input  logic signed [W-1:0] limit_i,
    input  logic                sub_i,
    output logic signed [W-1:0] y_o,
    output logic                at_limit_o
);

    logic signed [W:0] x_w;
    logic signed [W:0] step_w;
    logic signed [W:0] limit_w;
    logic signed [W:0] sum_w;

    assign x_w     = {x_i[W-1], x_i};
    assign step_w  = {step_i[W-1], step_i};
    assign limit_w = {limit_i[W-1], limit_i};

    always_comb begin
        sum_w      = sub_i ? (x_w - step_w) : (x_w + step_w);
        at_limit_o = sub_i ? (sum_w <= limit_w) : (sum_w >= limit_w);
        y_o        = at_limit_o ? limit_i : sum_w[W-1:0];
    end

endmodule

// File: rtl/adsr_phase.sv
// ADSR envelope phase generator producing the e^x exponent argument in [-1.0, 0].
// Optional macro ADSR_RETRIGGER_EN: retrig restarts ATTACK from -1.0 while the note is held.
module adsr_phase
    import adsr_pkg::*;
#(
    parameter int TOTAL_BITS      = 32,
    parameter int FRACTIONAL_BITS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  gate,
    input  logic                  tick,
    input  logic                  retrig,
    input  logic [TOTAL_BITS-1:0] attack_step,
    input  logic [TOTAL_BITS-1:0] decay_step,
    input  logic [TOTAL_BITS-1:0] release_step,
    input  logic [TOTAL_BITS-1:0] sustain_level,
    output logic [TOTAL_BITS-1:0] x_out,
    output logic                  x_valid,
    output logic [2:0]            state_out,
    output logic                  active
);

    localparam logic signed [TOTAL_BITS-1:0] X_MIN = TOTAL_BITS'(min_x_of(FRACTIONAL_BITS));

    adsr_state_e                  state_q, state_d, state_e;
    logic signed [TOTAL_BITS-1:0] x_q, x_d, x_e;
    logic                         gate_q;
    logic                         x_valid_q;

    logic signed [TOTAL_BITS-1:0] sc_step, sc_limit, sc_y;
    logic                         sc_sub, sc_at_limit;
    logic                         gate_rise, gate_fall, note_on;

    assign gate_rise = gate & ~gate_q;
    assign gate_fall = ~gate & gate_q;
    assign note_on   = (state_q == ST_ATTACK) || (state_q == ST_DECAY) || (state_q == ST_SUSTAIN);

    // Edge-driven transitions are resolved first so a coincident tick steps the new state.
    always_comb begin
        state_e = state_q;
        x_e     = x_q;
        if (gate_rise && (state_q == ST_IDLE || state_q == ST_RELEASE)) begin
            state_e = ST_ATTACK;
        end else if (gate_fall && note_on) begin
            state_e = ST_RELEASE;
        end
`ifdef ADSR_RETRIGGER_EN
        if (retrig && gate && note_on) begin
            state_e = ST_ATTACK;
            x_e     = X_MIN;
        end
`endif
    end

`ifndef ADSR_RETRIGGER_EN
    logic unused_retrig;
    assign unused_retrig = retrig;
`endif

    always_comb begin
        sc_step  = $signed(release_step);
        sc_limit = X_MIN;
        sc_sub   = 1'b1;
        case (state_e)
            ST_ATTACK: begin
                sc_step  = $signed(attack_step);
                sc_limit = '0;
                sc_sub   = 1'b0;
            end
            ST_DECAY: begin
                sc_step  = $signed(decay_step);
                sc_limit = $signed(sustain_level);
            end
            default: ;
        endcase
    end

    step_clamp #(.W(TOTAL_BITS)) u_step_clamp (
        .x_i        (x_e),
        .step_i     (sc_step),
        .limit_i    (sc_limit),
        .sub_i      (sc_sub),
        .y_o        (sc_y),
        .at_limit_o (sc_at_limit)
    );

    always_comb begin
        state_d = state_e;
        x_d     = x_e;
        if (tick) begin
            case (state_e)
                ST_ATTACK, ST_DECAY, ST_RELEASE: begin
                    // A zero step stalls the envelope, even when already at the limit.
                    if (sc_step != '0) begin
                        x_d = sc_y;
                        if (sc_at_limit) begin
                            case (state_e)
                                ST_ATTACK: state_d = ST_DECAY;
                                ST_DECAY:  state_d = ST_SUSTAIN;
                                default:   state_d = ST_IDLE;
                            endcase
                        end
                    end
                end
                ST_SUSTAIN: x_d = $signed(sustain_level);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            x_q       <= X_MIN;
            x_valid_q <= 1'b0;
            gate_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            x_valid_q <= tick;
            gate_q    <= gate;
        end
    end

    assign x_out     = x_q;
    assign x_valid   = x_valid_q;
    assign state_out = state_q;
    assign active    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adsr_phase.sv
// Self-checking bench for adsr_phase: directed scenarios plus randomized run against a reference model.
module tb_adsr_phase;

    localparam longint MINX = -65536;

    logic        clk = 1'b0;
    logic        reset, gate, tick, retrig;
    logic [31:0] attack_step, decay_step, release_step, sustain_level;
    logic [31:0] x_out;
    logic        x_valid, active;
    logic [2:0]  state_out;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: phase as 0..4 (idle, attack, decay, sustain, release), value as a plain integer.
    int     m_phase;
    longint m_x;
    logic   m_gprev, m_valid;

    always #5 clk = ~clk;

    adsr_phase #(.TOTAL_BITS(32), .FRACTIONAL_BITS(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .gate          (gate),
        .tick          (tick),
        .retrig        (retrig),
        .attack_step   (attack_step),
        .decay_step    (decay_step),
        .release_step  (release_step),
        .sustain_level (sustain_level),
        .x_out         (x_out),
        .x_valid       (x_valid),
        .state_out     (state_out),
        .active        (active)
    );

    task automatic model_update();
        int     ph;
        longint x, sus, a, d, r;
        if (reset) begin
            m_phase = 0; m_x = MINX; m_valid = 1'b0; m_gprev = 1'b0;
            return;
        end
        ph  = m_phase;
        x   = m_x;
        sus = longint'($signed(sustain_level));
        a   = longint'(attack_step);
        d   = longint'(decay_step);
        r   = longint'(release_step);
        if (gate && !m_gprev && (ph == 0 || ph == 4)) ph = 1;
        else if (!gate && m_gprev && ph >= 1 && ph <= 3) ph = 4;
`ifdef ADSR_RETRIGGER_EN
        if (retrig && gate && m_phase >= 1 && m_phase <= 3) begin ph = 1; x = MINX; end
`endif
        if (tick) begin
            if (ph == 1 && a != 0) begin
                x = x + a;
                if (x >= 0) begin x = 0; ph = 2; end
            end else if (ph == 2 && d != 0) begin
                x = x - d;
                if (x <= sus) begin x = sus; ph = 3; end
            end else if (ph == 3) begin
                x = sus;
            end else if (ph == 4 && r != 0) begin
                x = x - r;
                if (x <= MINX) begin x = MINX; ph = 0; end
            end
        end
        m_gprev = gate;
        m_valid = tick;
        m_phase = ph;
        m_x     = x;
    endtask

    task automatic cycle();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; gate = 1'b1; tick = 1'b1; retrig = 1'b1;
        attack_step = 32'h4000; decay_step = 32'h0; release_step = 32'h0;
        sustain_level = 32'hFFFF8000;
        cycle();
        cycle();
        n_checks++;
        if (x_out !== 32'hFFFF0000) $display("FAIL reset_x got %0d want %0d", $signed(x_out), MINX);
        else n_pass++;
        n_checks++;
        if (state_out !== 3'd0) $display("FAIL reset_state got %0d want 0", state_out);
        else n_pass++;
        n_checks++;
        if (active !== 1'b0) $display("FAIL reset_active got %b want 0", active);
        else n_pass++;
        n_checks++;
        if (x_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", x_valid);
        else n_pass++;
        retrig = 1'b0;
    endtask

    task automatic test_attack();
        int exp_x[4] = '{-32'sh0C000, -32'sh08000, -32'sh04000, 32'sh0};
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++;
            if (x_out !== 32'(exp_x[i]) || x_valid !== 1'b1)
                $display("FAIL attack_x[%0d] got %0d valid %b want %0d valid 1", i, $signed(x_out), x_valid, exp_x[i]);
            else n_pass++;
        end
        n_checks++;
        if (state_out !== 3'd2) $display("FAIL attack_to_decay got %0d want 2", state_out);
        else n_pass++;
    endtask

    task automatic test_decay();
        int exp_x[3] = '{-32'sh3000, -32'sh6000, -32'sh8000};
        decay_step = 32'h3000;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (x_out !== 32'(exp_x[i])) $display("FAIL decay_x[%0d] got %0d want %0d", i, $signed(x_out), exp_x[i]);
            else n_pass++;
        end
        n_checks++;
        if (state_out !== 3'd3) $display("FAIL decay_to_sustain got %0d want 3", state_out);
        else n_pass++;
        cycle();
        cycle();
        n_checks++;
        if (x_out !== 32'hFFFF8000 || state_out !== 3'd3)
            $display("FAIL sustain_hold got x %0d state %0d want x -32768 state 3", $signed(x_out), state_out);
        else n_pass++;
    endtask

    task automatic test_release();
        int exp_x[2] = '{-32'shD000, -32'sh10000};
        gate = 1'b0; release_step = 32'h5000;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_checks++;
            if (x_out !== 32'(exp_x[i])) $display("FAIL release_x[%0d] got %0d want %0d", i, $signed(x_out), exp_x[i]);
            else n_pass++;
        end
        n_checks++;
        if (state_out !== 3'd0 || active !== 1'b0)
            $display("FAIL release_to_idle got state %0d active %b want state 0 active 0", state_out, active);
        else n_pass++;
        tick = 1'b0;
        cycle();
        n_checks++;
        if (x_valid !== 1'b0) $display("FAIL idle_no_tick_valid got %b want 0", x_valid);
        else n_pass++;
    endtask

    task automatic test_rise_in_release();
        gate = 1'b1; tick = 1'b1; attack_step = 32'h3000;
        cycle();
        gate = 1'b0; tick = 1'b0;
        cycle();
        n_checks++;
        if (state_out !== 3'd4 || x_out !== 32'hFFFF3000)
            $display("FAIL release_setup got state %0d x %0d want state 4 x -53248", state_out, $signed(x_out));
        else n_pass++;
        gate = 1'b1; tick = 1'b1; attack_step = 32'h1000;
        cycle();
        n_checks++;
        if (state_out !== 3'd1 || x_out !== 32'hFFFF4000)
            $display("FAIL rise_in_release got state %0d x %0d want state 1 x -49152", state_out, $signed(x_out));
        else n_pass++;
    endtask

    task automatic test_large_step();
        reset = 1'b1; tick = 1'b0;
        cycle();
        reset = 1'b0; tick = 1'b1; attack_step = 32'h7FFFFFFF;
        decay_step = 32'h1000; sustain_level = 32'hFFFF8000;
        cycle();
        n_checks++;
        if (x_out !== 32'h0 || state_out !== 3'd2)
            $display("FAIL big_attack got x %0d state %0d want x 0 state 2", $signed(x_out), state_out);
        else n_pass++;
        cycle();
        reset = 1'b1;
        cycle();
        n_checks++;
        if (state_out !== 3'd0 || x_out !== 32'hFFFF0000 || x_valid !== 1'b0 || active !== 1'b0)
            $display("FAIL reset_mid_decay got state %0d x %0d valid %b active %b want 0 -65536 0 0", state_out, $signed(x_out), x_valid, active);
        else n_pass++;
    endtask

    task automatic test_retrig();
        logic [2:0]  exp_st;
        logic [31:0] exp_x;
        reset = 1'b0; gate = 1'b1; tick = 1'b1;
        attack_step = 32'h10000; decay_step = 32'h8000; sustain_level = 32'hFFFF8000;
        cycle();
        cycle();
        tick = 1'b0; retrig = 1'b1;
        cycle();
        retrig = 1'b0;
`ifdef ADSR_RETRIGGER_EN
        exp_st = 3'd1; exp_x = 32'hFFFF0000;
`else
        exp_st = 3'd3; exp_x = 32'hFFFF8000;
`endif
        n_checks++;
        if (state_out !== exp_st || x_out !== exp_x)
            $display("FAIL retrig got state %0d x %0d want state %0d x %0d", state_out, $signed(x_out), exp_st, $signed(exp_x));
        else n_pass++;
    endtask

    function automatic logic [31:0] rand_step();
        case ($urandom_range(3, 0))
            0: return 32'h0;
            1: return 32'($urandom_range(32'h800, 1));
            2: return 32'($urandom_range(32'h20000, 32'h800));
            default: return 32'h7FFFFFFF;
        endcase
    endfunction

    task automatic test_random();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(19, 0) == 0) gate = ~gate;
            tick   = ($urandom_range(1, 0) == 1);
            retrig = ($urandom_range(15, 0) == 0);
            reset  = ($urandom_range(149, 0) == 0);
            if ($urandom_range(7, 0) == 0) attack_step = rand_step();
            if ($urandom_range(7, 0) == 0) decay_step = rand_step();
            if ($urandom_range(7, 0) == 0) release_step = rand_step();
            if ($urandom_range(15, 0) == 0) sustain_level = 32'(-longint'($urandom_range(65536, 0)));
            cycle();
            n_checks++;
            if (longint'($signed(x_out)) !== m_x || int'(state_out) != m_phase || x_valid !== m_valid || active !== (m_phase != 0))
                $display("FAIL random[%0d] got x %0d st %0d v %b a %b want x %0d st %0d v %b a %b", i, $signed(x_out), state_out, x_valid, active, m_x, m_phase, m_valid, (m_phase != 0));
            else n_pass++;
        end
        reset = 1'b0; retrig = 1'b0;
    endtask

    initial begin
        m_phase = 0; m_x = MINX; m_gprev = 1'b0; m_valid = 1'b0;
        test_reset();
        test_attack();
        test_decay();
        test_release();
        test_rise_in_release();
        test_large_step();
        test_retrig();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
